pipe_stage_chain: RTL and testbench

//  Parametrised elastic pipeline register; successor to fixed single-stage inter-stage regs (MEM->MEM2).

---
 rtl/pipe_stage_chain.sv | 117 +++++++++++
 tb/tb_pipe_stage_chain.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_chain.sv
// Elastic pipeline register chain: DEPTH valid/ready slots with bubble collapsing and flush.
// Optional PIPE_STAGE_PERF_EN adds the occupancy and stall_cnt performance ports.
module pipe_stage_chain #(
    parameter int unsigned      WIDTH   = 32,
    parameter int unsigned      DEPTH   = 2,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [2:0]       occupancy,
    output logic [31:0]      stall_cnt
`endif
);

    logic [DEPTH-1:0] v_q;
    logic [DEPTH-1:0] v_d;
    logic [DEPTH-1:0] slotRdy;
    logic [WIDTH-1:0] d_q [DEPTH];
    logic [WIDTH-1:0] d_d [DEPTH];

    // A slot can load when it is empty or its content moves on; walked from the output back.
    always_comb begin : readyChain
        logic downRdy;
        downRdy = out_ready;
        slotRdy = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            slotRdy[i] = !v_q[i] || downRdy;
            downRdy    = slotRdy[i];
        end
    end

    assign in_ready  = slotRdy[0];
    assign out_valid = v_q[DEPTH-1];
    assign out_data  = d_q[DEPTH-1];

    // Payload registers change only when a valid payload is actually moved in.
    always_comb begin
        v_d = v_q;
        d_d = d_q;
        if (slotRdy[0]) begin
            v_d[0] = in_valid;
            if (in_valid) begin
                d_d[0] = in_data;
            end
        end
        for (int i = 1; i < DEPTH; i++) begin
            if (slotRdy[i]) begin
                v_d[i] = v_q[i-1];
                if (v_q[i-1]) begin
                    d_d[i] = d_q[i-1];
                end
            end
        end
        if (flush) begin
            v_d = '0;
            for (int i = 0; i < DEPTH; i++) begin
                d_d[i] = RST_VAL;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                d_q[i] <= RST_VAL;
            end
        end else begin
            v_q <= v_d;
            for (int i = 0; i < DEPTH; i++) begin
                d_q[i] <= d_d[i];
            end
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    logic [31:0] stall_q;
    logic [31:0] stall_d;

    always_comb begin
        occupancy = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occupancy = occupancy + {2'b00, v_q[i]};
        end
    end

    // Saturating count of cycles the head payload waits on downstream; flush leaves it alone.
    always_comb begin
        stall_d = stall_q;
        if (out_valid && !out_ready && (stall_q != 32'hFFFF_FFFF)) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt = stall_q;
`else
    // Without the performance option the chain carries no counters.
`endif

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Self-checking bench for pipe_stage_chain: directed scenarios then random traffic,
// compared against a queue-based model of a DEPTH-deep elastic FIFO with fixed latency.
module tb_pipe_stage_chain;

    localparam int          W  = 32;
    localparam int          D  = 2;
    localparam logic [W-1:0] RV = 32'hA5A5_0F0F;

    typedef struct {
        logic [W-1:0] data;
        int           entry;
    } item_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         flush;
    logic         inValid;
    logic         inReady;
    logic [W-1:0] inData;
    logic         outValid;
    logic         outReady;
    logic [W-1:0] outData;
`ifdef PIPE_STAGE_PERF_EN
    logic [2:0]   occupancy;
    logic [31:0]  stallCnt;
    int unsigned  stallExp = 0;
`endif

    int           checks    = 0;
    int           failures  = 0;
    int           cyc       = 0;
    int           lastLeave = -100;
    bit           known     = 1'b0;
    logic [W-1:0] lastOut   = RV;
    item_t        q[$];

    pipe_stage_chain #(.WIDTH(W), .DEPTH(D), .RST_VAL(RV)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (inValid),
        .in_ready  (inReady),
        .in_data   (inData),
        .out_valid (outValid),
        .out_ready (outReady),
        .out_data  (outData)
`ifdef PIPE_STAGE_PERF_EN
        ,
        .occupancy (occupancy),
        .stall_cnt (stallCnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h cycle=%0d", tag, obs, exp, cyc);
        end
    endtask

    // One clock cycle: drive inputs, check outputs against the model, then advance the model.
    task automatic applyStimulus(input logic iv, input logic [W-1:0] id, input logic ordy,
                                 input logic fl, input logic rs);
        logic         expValid;
        logic         expReady;
        logic [W-1:0] expData;
        int           headVis;
        inValid  = iv;
        inData   = id;
        outReady = ordy;
        flush    = fl;
        rst      = rs;
        #1;
        expValid = 1'b0;
        expReady = 1'b1;
        expData  = lastOut;
        if (known) begin
            if (q.size() > 0) begin
                headVis = q[0].entry + D;
                if (lastLeave + 1 > headVis) headVis = lastLeave + 1;
                expValid = (cyc >= headVis);
            end
            if (expValid) expData = q[0].data;
            expReady = (q.size() < D) || ordy;
            checkOutput("out_valid", {31'b0, outValid}, {31'b0, expValid});
            checkOutput("out_data", outData, expData);
            checkOutput("in_ready", {31'b0, inReady}, {31'b0, expReady});
`ifdef PIPE_STAGE_PERF_EN
            checkOutput("occupancy", {29'b0, occupancy}, q.size());
            checkOutput("stall_cnt", stallCnt, stallExp);
`endif
        end
        @(posedge clk);
        if (rs) begin
            q.delete();
            lastOut   = RV;
            lastLeave = cyc;
            known     = 1'b1;
`ifdef PIPE_STAGE_PERF_EN
            stallExp  = 0;
`endif
        end else if (known) begin
`ifdef PIPE_STAGE_PERF_EN
            if (expValid && !ordy && stallExp != 32'hFFFF_FFFF) stallExp++;
`endif
            if (fl) begin
                q.delete();
                lastOut = RV;
            end else begin
                if (expValid && ordy) begin
                    lastOut = q[0].data;
                    void'(q.pop_front());
                    lastLeave = cyc;
                end
                if (iv && expReady) q.push_back('{data: id, entry: cyc});
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; inValid = 1'b0; inData = '0; outReady = 1'b0;
        $display("[TB] pipe_stage_chain WIDTH=%0d DEPTH=%0d", W, D);
        @(negedge clk);

        // Reset for two cycles, then observe the idle state.
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);

        // Streaming: five payloads back to back with the sink always ready.
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 32'h1000_0000 + i, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);

        // Backpressure: fill the chain, third push waits until the sink becomes ready.
        applyStimulus(1'b1, 32'h2000_000A, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h2000_000B, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h2000_000C, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h2000_000C, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);

        // Bubble collapse: A, gap, B into a stalled chain.
        applyStimulus(1'b1, 32'h3000_00AA, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h3000_00BB, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);

        // Flush with both slots full and a payload offered: everything is dropped.
        applyStimulus(1'b1, 32'h3000_00CC, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);

        // Stall counting from a clean reset: 7 stalled cycles, flush keeps it, reset clears it.
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 32'h4000_0001, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);

        // Random traffic with occasional flush and reset.
        for (int i = 0; i < 500; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), $urandom, ($urandom_range(0, 9) < 7),
                          ($urandom_range(0, 39) == 0), ($urandom_range(0, 149) == 0));
        end
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
